tone_writer: RTL and testbench
==============================

Name: tone_writer

Overview:
- Reference-tone generator that feeds the Audio_Controller output FIFO, acting as the writer on the audio_out_allowed / write_audio_out interface.
- Plays the open-string pitch of a selected guitar string (E2, A2, D3, G3, B3, E4) at the 48 kHz codec rate, so players can tune by ear against the FPGA tuner.
- Produces a square or triangle wave, optionally in bursts (tone, then silence).
- Sample pacing comes entirely from FIFO backpressure: one sample is written per accepted write.

Parameters:
- BURST_LEN, 48000: samples written per tone burst; 0 = continuous tone, no GAP state.
- GAP_LEN, 12000: zero samples written between bursts; must be >= 1 when BURST_LEN > 0.
- TRI_SHIFT, 10: base attenuation shift. Base peak amplitude = 2^(30-TRI_SHIFT).

Ports:
- CLOCK_50  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  play request (top level drives it from a switch)
- string_sel  in  3  0=E2 1=A2 2=D3 3=G3 4=B3 5=E4; 6,7 invalid
- wave_sel  in  1  0=square, 1=triangle
- volume  in  3  left shift applied to the base amplitude
- audio_out_allowed  in  1  Audio_Controller output FIFO has space
- write_audio_out  out  1  write strobe; one sample accepted per high cycle
- left_channel_audio_out  out  32  signed sample
- right_channel_audio_out  out  32  same value as left
- busy  out  1  state != IDLE

Behaviour:
- Reset (synchronous; overrides everything, including mid-burst):
  - state=IDLE, phase=0, counters=0.
  - Sample register=0, so both channel outputs=0.
  - write_audio_out=0, busy=0.
- write_audio_out = (state==PLAY || state==GAP) && audio_out_allowed. This is the only combinational path. A "write" is a cycle where write_audio_out is high.
- Channel outputs are driven directly from the sample register. They are valid whenever write_audio_out is high, and hold their value while no write occurs.
- Phase increment ROM (32-bit phase accumulator, inc = f*2^32/48000):
  - E2 7373645
  - A2 9842633
  - D3 13138305
  - G3 17537783
  - B3 22095996
  - E4 29494614
  - string_sel 6 or 7 means invalid: inc=0 and samples are forced to 0. Writes still occur.
- Waveform, computed from phase p and latched volume v:
  - square: p[31]==0 gives +(2^(30-TRI_SHIFT) << v); otherwise the negative of that.
  - triangle: t = p[31] ? ~p[30:0] : p[30:0]; c = {1'b0,t} - 2^30 (signed 32-bit); sample = (c >>> TRI_SHIFT) << v.
  - Range: at most 2^27 magnitude with defaults, so no overflow.
- States:
  - IDLE, when enable=1:
    - latch string_sel, wave_sel and volume;
    - set phase=0, burst count=0;
    - load the sample register with wave(0);
    - go to PLAY next cycle.
    - First write is therefore possible 1 cycle after enable is sampled high.
  - PLAY, on each write:
    - phase += inc;
    - sample register = wave(phase+inc);
    - count++.
    - If BURST_LEN>0 and this write is write number BURST_LEN: load sample register=0, clear count, go to GAP.
  - GAP, on each write:
    - sample stays 0; count++.
    - On write number GAP_LEN: if enable=1, relatch the settings, set phase=0, load wave(0) and go to PLAY; otherwise go to IDLE.
  - In PLAY or GAP with enable=0: go to IDLE next cycle and clear the sample register. An enable drop takes priority over a write in the same cycle; that write still completes with the current sample.
- Inputs string_sel, wave_sel and volume are ignored except at PLAY entry; changes mid-burst have no effect.
- No write in a cycle (audio_out_allowed=0) means phase, count and sample all hold. There is no sample loss or duplication under backpressure.
- Phase wraps modulo 2^32 naturally.

Decomposition:
- Package tone_pkg holds:
  - state enum IDLE / PLAY / GAP;
  - string index constants;
  - the 6-entry phase-increment constant array (the tuner's detector reuses the same pitch table).
- One sub-module, tone_wave_gen: combinational phase + wave_sel + volume -> 32-bit sample.
- FSM, counters and accumulator stay in tone_writer.

Test Plan:
- Reset: assert reset 3 cycles with enable=1 and allowed=1 -> write_audio_out=0, outputs 0, busy=0. Release -> busy=1 one cycle later.
- Continuous A2 square (BURST_LEN=0, v=0, allowed=1): enable -> first sample 0x00100000 for writes 0..218; write 219 = 0xFFF00000; phase after 10 writes = 98426330.
- Burst (BURST_LEN=4, GAP_LEN=2, E4 square, v=2): write sequence = 4x 0x00400000, 2x 0, 4x 0x00400000, with phase restarting at 0 each burst.
- Backpressure: allowed pattern 1,0,0,1,1 -> exactly 3 writes, phase = 3*inc, outputs held during the low cycles.
- Enable drop / mid-burst change: drop enable in PLAY -> IDLE next cycle, write=0, outputs 0. Change string_sel 1->3 mid-PLAY -> increment stays 9842633 until the next PLAY entry.
- Triangle and invalid string: triangle, v=3, string 0 -> first sample 0xFF800000 (-2^23), increasing thereafter. string_sel=6 -> writes continue and all samples are 0.

Source files
------------

// File: rtl/tone_pkg.sv
// Shared definitions for the reference-tone writer.
// The pitch table is also used by the tuner's detector.
package tone_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } tone_state_e;

    localparam logic [2:0] STR_E2 = 3'd0;
    localparam logic [2:0] STR_A2 = 3'd1;
    localparam logic [2:0] STR_D3 = 3'd2;
    localparam logic [2:0] STR_G3 = 3'd3;
    localparam logic [2:0] STR_B3 = 3'd4;
    localparam logic [2:0] STR_E4 = 3'd5;

    localparam int NUM_STRINGS = 6;

    // inc = f * 2^32 / 48000 for each open string
    localparam logic [31:0] PHASE_INC [0:NUM_STRINGS-1] = '{
        32'd7373645,
        32'd9842633,
        32'd13138305,
        32'd17537783,
        32'd22095996,
        32'd29494614
    };

    function automatic logic string_valid(input logic [2:0] sel);
        return (sel <= STR_E4);
    endfunction

    // Invalid selections step nowhere so the accumulator stays put.
    function automatic logic [31:0] phase_inc(input logic [2:0] sel);
        logic [31:0] inc;
        inc = '0;
        unique case (sel)
            STR_E2:  inc = PHASE_INC[0];
            STR_A2:  inc = PHASE_INC[1];
            STR_D3:  inc = PHASE_INC[2];
            STR_G3:  inc = PHASE_INC[3];
            STR_B3:  inc = PHASE_INC[4];
            STR_E4:  inc = PHASE_INC[5];
            default: inc = '0;
        endcase
        return inc;
    endfunction

endpackage

// File: rtl/tone_wave_gen.sv
// Phase-to-sample shaper: square or triangle, scaled by volume.
// Purely combinational; muted output is forced to zero.
module tone_wave_gen #(
    parameter int TRI_SHIFT = 10
) (
    input  logic [31:0] phase,
    input  logic        wave_sel,
    input  logic [2:0]  volume,
    input  logic        mute,
    output logic [31:0] sample
);

    localparam logic [31:0] BASE_AMP = 32'd1 << (30 - TRI_SHIFT);
    localparam logic [31:0] TRI_MID  = 32'h4000_0000;

    logic [30:0]        tri_t;
    logic signed [31:0] tri_c;
    logic signed [31:0] tri_s;
    logic [31:0]        sq_amp;
    logic [31:0]        sq_s;

    // Shape the current phase into a signed sample
    always_comb begin
        tri_t  = phase[31] ? ~phase[30:0] : phase[30:0];
        tri_c  = $signed({1'b0, tri_t} - TRI_MID);
        tri_s  = (tri_c >>> TRI_SHIFT) <<< volume;
        sq_amp = BASE_AMP << volume;
        sq_s   = phase[31] ? (~sq_amp + 32'd1) : sq_amp;
        sample = '0;
        if (!mute) begin
            sample = wave_sel ? tri_s : sq_s;
        end
    end

endmodule

// File: rtl/tone_writer.sv
// Reference-tone generator writing into the audio output FIFO.
// Pacing comes from FIFO backpressure: one sample per write.
module tone_writer
    import tone_pkg::*;
#(
    parameter int unsigned BURST_LEN = 48000,
    parameter int unsigned GAP_LEN   = 12000,
    parameter int          TRI_SHIFT = 10
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        enable,
    input  logic [2:0]  string_sel,
    input  logic        wave_sel,
    input  logic [2:0]  volume,
    input  logic        audio_out_allowed,
    output logic        write_audio_out,
    output logic [31:0] left_channel_audio_out,
    output logic [31:0] right_channel_audio_out,
    output logic        busy
);

    localparam logic        BURSTY     = (BURST_LEN != 0);
    localparam logic [31:0] BURST_LAST = 32'(BURST_LEN - 1);
    localparam logic [31:0] GAP_LAST   = 32'(GAP_LEN - 1);

    tone_state_e state_q;
    logic [31:0] phase_q;
    logic [31:0] count_q;
    logic [31:0] sample_q;
    logic [2:0]  str_q;
    logic        wave_q;
    logic [2:0]  vol_q;

    logic [31:0] inc;
    logic [31:0] next_phase;
    logic        play_last;
    logic        gap_last;
    logic        restart;

    logic [31:0] wg_phase;
    logic        wg_wave;
    logic [2:0]  wg_vol;
    logic        wg_mute;
    logic [31:0] wg_sample;

    assign write_audio_out = ((state_q == ST_PLAY) || (state_q == ST_GAP))
                             && audio_out_allowed;

    assign left_channel_audio_out  = sample_q;
    assign right_channel_audio_out = sample_q;
    assign busy = (state_q != ST_IDLE);

    // Burst bookkeeping and the one shared wave-generator input mux
    always_comb begin
        inc        = phase_inc(str_q);
        next_phase = phase_q + inc;
        play_last  = BURSTY && (count_q == BURST_LAST);
        gap_last   = (count_q == GAP_LAST);
        restart    = 1'b0;
        if ((state_q == ST_IDLE) && enable) begin
            restart = 1'b1;
        end
        if ((state_q == ST_GAP) && enable && write_audio_out && gap_last) begin
            restart = 1'b1;
        end
        wg_phase = next_phase;
        wg_wave  = wave_q;
        wg_vol   = vol_q;
        wg_mute  = !string_valid(str_q);
        if (restart) begin
            wg_phase = '0;
            wg_wave  = wave_sel;
            wg_vol   = volume;
            wg_mute  = !string_valid(string_sel);
        end
    end

    tone_wave_gen #(
        .TRI_SHIFT (TRI_SHIFT)
    ) u_wave (
        .phase    (wg_phase),
        .wave_sel (wg_wave),
        .volume   (wg_vol),
        .mute     (wg_mute),
        .sample   (wg_sample)
    );

    // Play/gap sequencer, phase accumulator and sample register
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            phase_q  <= '0;
            count_q  <= '0;
            sample_q <= '0;
            str_q    <= '0;
            wave_q   <= 1'b0;
            vol_q    <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        str_q    <= string_sel;
                        wave_q   <= wave_sel;
                        vol_q    <= volume;
                        phase_q  <= '0;
                        count_q  <= '0;
                        sample_q <= wg_sample;
                        state_q  <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (!enable) begin
                        sample_q <= '0;
                        count_q  <= '0;
                        state_q  <= ST_IDLE;
                    end else if (write_audio_out) begin
                        phase_q <= next_phase;
                        if (play_last) begin
                            sample_q <= '0;
                            count_q  <= '0;
                            state_q  <= ST_GAP;
                        end else begin
                            sample_q <= wg_sample;
                            count_q  <= count_q + 32'd1;
                        end
                    end
                end
                ST_GAP: begin
                    if (!enable) begin
                        sample_q <= '0;
                        count_q  <= '0;
                        state_q  <= ST_IDLE;
                    end else if (write_audio_out) begin
                        if (gap_last) begin
                            str_q    <= string_sel;
                            wave_q   <= wave_sel;
                            vol_q    <= volume;
                            phase_q  <= '0;
                            count_q  <= '0;
                            sample_q <= wg_sample;
                            state_q  <= ST_PLAY;
                        end else begin
                            count_q <= count_q + 32'd1;
                        end
                    end
                end
                default: begin
                    sample_q <= '0;
                    count_q  <= '0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tone_writer.sv
// Randomized bench for tone_writer: continuous and burst builds
// checked every cycle against a write-count reference model.
module tb_tone_writer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [2:0] string_sel = '0;
    logic       wave_sel = 1'b0;
    logic [2:0] volume = '0;
    logic       allowed = 1'b0;

    logic        wr [2];
    logic        bz [2];
    logic [31:0] lc [2];
    logic [31:0] rc [2];

    always #10 clk = ~clk;

    tone_writer #(.BURST_LEN(0), .GAP_LEN(1), .TRI_SHIFT(10)) dut_c (
        .CLOCK_50                (clk),
        .reset                   (reset),
        .enable                  (enable),
        .string_sel              (string_sel),
        .wave_sel                (wave_sel),
        .volume                  (volume),
        .audio_out_allowed       (allowed),
        .write_audio_out         (wr[0]),
        .left_channel_audio_out  (lc[0]),
        .right_channel_audio_out (rc[0]),
        .busy                    (bz[0])
    );

    tone_writer #(.BURST_LEN(4), .GAP_LEN(2), .TRI_SHIFT(10)) dut_b (
        .CLOCK_50                (clk),
        .reset                   (reset),
        .enable                  (enable),
        .string_sel              (string_sel),
        .wave_sel                (wave_sel),
        .volume                  (volume),
        .audio_out_allowed       (allowed),
        .write_audio_out         (wr[1]),
        .left_channel_audio_out  (lc[1]),
        .right_channel_audio_out (rc[1]),
        .busy                    (bz[1])
    );

    int checks = 0;
    int failures = 0;
    int wcount = 0;

    longint inc_tab [6] = '{7373645, 9842633, 13138305,
                            17537783, 22095996, 29494614};
    longint bl [2] = '{0, 4};
    longint gl [2] = '{1, 2};

    bit     m_act [2];
    longint m_n   [2];
    int     m_str [2];
    bit     m_wav [2];
    int     m_vol [2];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_wave(input longint p, input bit tri_w,
                                             input int v);
        longint a;
        longint t;
        longint c;
        if (!tri_w) begin
            a = longint'(1) << (20 + v);
            return (p < 64'h8000_0000) ? 32'(a) : 32'(-a);
        end
        t = (p < 64'h8000_0000) ? p : (64'hFFFF_FFFF - p);
        c = t - 64'h4000_0000;
        c = c >>> 10;
        return 32'(c * (longint'(1) << v));
    endfunction

    function automatic logic [31:0] ref_out(input int d);
        longint pos;
        if (!m_act[d]) return 32'd0;
        pos = (bl[d] == 0) ? m_n[d] : m_n[d] % (bl[d] + gl[d]);
        if (bl[d] > 0 && pos >= bl[d]) return 32'd0;
        if (m_str[d] > 5) return 32'd0;
        return ref_wave((pos * inc_tab[m_str[d]]) % (longint'(1) << 32),
                        m_wav[d], m_vol[d]);
    endfunction

    task automatic latch_settings(input int d);
        m_str[d] = int'(string_sel);
        m_wav[d] = wave_sel;
        m_vol[d] = int'(volume);
    endtask

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                m_act[d] = 1'b0;
                m_n[d]   = 0;
            end else if (!m_act[d]) begin
                if (enable) begin
                    m_act[d] = 1'b1;
                    m_n[d]   = 0;
                    latch_settings(d);
                end
            end else if (!enable) begin
                m_act[d] = 1'b0;
            end else if (allowed) begin
                if (bl[d] > 0 &&
                    (m_n[d] % (bl[d] + gl[d])) == bl[d] + gl[d] - 1) begin
                    latch_settings(d);
                end
                m_n[d]++;
            end
        end
    endtask

    task automatic cyc();
        #1;
        if (wr[0]) wcount++;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("write%0d", d), 32'(wr[d]),
                  32'(m_act[d] && allowed));
            check($sformatf("busy%0d", d), 32'(bz[d]), 32'(m_act[d]));
            check($sformatf("left%0d", d), lc[d], ref_out(d));
            check($sformatf("right%0d", d), rc[d], ref_out(d));
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    bit bp_pat [5] = '{1, 0, 0, 1, 1};

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_act[d] = 1'b0;
            m_n[d]   = 0;
            m_str[d] = 0;
            m_wav[d] = 1'b0;
            m_vol[d] = 0;
        end
        reset = 1'b1;
        enable = 1'b1;
        allowed = 1'b1;
        string_sel = 3'd1;
        wave_sel = 1'b0;
        volume = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        repeat (3) cyc();
        check("rst_busy", 32'(bz[0]), 32'd0);
        check("rst_left", lc[0], 32'd0);

        reset = 1'b0;
        cyc();
        check("busy_after_rel", 32'(bz[0]), 32'd1);
        check("first_a2", lc[0], 32'h0010_0000);
        repeat (50) cyc();
        string_sel = 3'd3;
        repeat (169) cyc();
        check("a2_w219", lc[0], 32'hFFF0_0000);

        enable = 1'b0;
        cyc();
        check("drop_busy", 32'(bz[0]), 32'd0);
        check("drop_left", lc[0], 32'd0);

        string_sel = 3'd5;
        wave_sel = 1'b0;
        volume = 3'd2;
        enable = 1'b1;
        cyc();
        check("burst_first", lc[1], 32'h0040_0000);
        repeat (12) cyc();

        wcount = 0;
        for (int i = 0; i < 5; i++) begin
            allowed = bp_pat[i];
            cyc();
        end
        check("bp_writes", 32'(wcount), 32'd3);
        allowed = 1'b1;

        enable = 1'b0;
        cyc();
        string_sel = 3'd0;
        wave_sel = 1'b1;
        volume = 3'd3;
        enable = 1'b1;
        cyc();
        check("tri_first", lc[0], 32'hFF80_0000);
        repeat (20) cyc();

        enable = 1'b0;
        cyc();
        string_sel = 3'd6;
        enable = 1'b1;
        cyc();
        repeat (10) cyc();
        check("inv_write", 32'(wr[0]), 32'd1);
        check("inv_left", lc[0], 32'd0);

        for (int i = 0; i < 4000; i++) begin
            reset   = ($urandom_range(0, 199) == 0);
            enable  = ($urandom_range(0, 39) != 0);
            allowed = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 9) == 0) begin
                string_sel = 3'($urandom_range(0, 7));
                wave_sel   = 1'($urandom_range(0, 1));
                volume     = 3'($urandom_range(0, 7));
            end
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
